// File: rtl/tsen_ctrl_pkg.sv
// Shared definitions for the temperature-sensor sequencer: FSM states,
// register offsets, STATUS bit positions and mask-scan helpers.
package tsen_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StCapture,
    StNext
  } state_e;

  // The register map extends to 0x20, so the byte address needs six bits.
  localparam int AddrW = 6;

  localparam logic [AddrW-1:0] AddrCtrl    = 6'h00;
  localparam logic [AddrW-1:0] AddrPeriod  = 6'h04;
  localparam logic [AddrW-1:0] AddrTimeout = 6'h08;
  localparam logic [AddrW-1:0] AddrStatus  = 6'h0C;
  localparam logic [AddrW-1:0] AddrData0   = 6'h10;
  localparam logic [AddrW-1:0] AddrTstamp  = 6'h1C;
  localparam logic [AddrW-1:0] AddrIntrEn  = 6'h20;

  localparam int StatusBusyBit = 0;
  localparam int StatusDoneBit = 1;
  localparam int StatusTerrBit = 2;
  localparam int StatusOvrBit  = 3;

  function automatic logic [1:0] nextSel(input logic [3:0] mask, input logic [1:0] from);
    nextSel = from;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (2'(i) >= from)) nextSel = 2'(i);
    end
  endfunction

  function automatic logic anyAbove(input logic [3:0] mask, input logic [1:0] idx);
    anyAbove = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i] && (2'(i) > idx)) anyAbove = 1'b1;
    end
  endfunction

endpackage

// File: rtl/tsen_ctrl_timer.sv
// Periodic trigger source: counts while enabled and emits a one-cycle tick
// every period_i cycles; period_i == 0 keeps it silent.
module tsen_ctrl_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        active;

  assign active = en_i && (period_i != '0);
  // >= keeps the counter from running off if PERIOD is lowered mid-count.
  assign tick_o = active && (cnt_q >= period_i - 32'd1);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (!active || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tsen_ctrl.sv
// Temperature-sensor sequencer with a small register file. Optional feature:
// define TSEN_CTRL_TIMESTAMP_EN to latch a free-running cycle count at sweep end.
module tsen_ctrl
  import tsen_ctrl_pkg::*;
#(
  parameter int NumSensors = 2,
  parameter int DataW      = 24,
  parameter int TimeoutW   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             reg_we_i,
  input  logic             reg_re_i,
  input  logic [AddrW-1:0] reg_addr_i,
  input  logic [31:0]      reg_wdata_i,
  output logic [31:0]      reg_rdata_o,
  output logic [1:0]       sen_sel_o,
  output logic             sen_start_o,
  input  logic             sen_done_i,
  input  logic [DataW-1:0] sen_data_i,
  output logic             intr_o
);

  localparam logic [3:0] ValidMask = 4'((1 << NumSensors) - 1);

  state_e              state_q;
  logic                enable_q, periodic_q, intrEn_q;
  logic [3:0]          mask_q;
  logic [31:0]         period_q;
  logic [TimeoutW-1:0] timeout_q, waitCnt_q;
  logic                done_q, terr_q, ovr_q;
  logic [1:0]          idx_q, sel_q;
  logic                start_q;
  logic [DataW-1:0]    data_q [NumSensors];

  logic       ctrlWe, statusWe, enNext, tick, startTrig, trig, busy;
  logic       timeoutHit, moreLeft, doneSet, terrSet, ovrSet, captureEn;
  logic [3:0] effMask;
  logic [1:0] selNext;
  logic       unusedRe;

  assign unusedRe = reg_re_i;

  tsen_ctrl_timer u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (enable_q & periodic_q),
    .period_i (period_q),
    .tick_o   (tick)
  );

  assign ctrlWe   = reg_we_i && (reg_addr_i == AddrCtrl);
  assign statusWe = reg_we_i && (reg_addr_i == AddrStatus);
  // A CTRL write clearing enable aborts the sweep at that same edge.
  assign enNext   = ctrlWe ? reg_wdata_i[0] : enable_q;
  assign effMask  = mask_q & ValidMask;

  assign startTrig  = ctrlWe && reg_wdata_i[2] && reg_wdata_i[0] &&
                      ((reg_wdata_i[7:4] & ValidMask) != 4'd0);
  assign trig       = startTrig || (tick && (effMask != 4'd0));
  assign busy       = (state_q != StIdle);
  assign timeoutHit = (timeout_q != '0) && (waitCnt_q == timeout_q - TimeoutW'(1));
  assign moreLeft   = anyAbove(effMask, idx_q);
  assign selNext    = nextSel(effMask, idx_q);

  assign doneSet   = (state_q == StNext) && enNext && !moreLeft;
  assign terrSet   = (state_q == StWait) && enNext && !sen_done_i && timeoutHit;
  assign captureEn = (state_q == StWait) && enNext && sen_done_i;
  assign ovrSet    = busy && trig;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      sel_q     <= '0;
      start_q   <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (busy && !enNext) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: if (trig && enNext) begin
            state_q <= StStart;
            idx_q   <= '0;
          end
          StStart: begin
            idx_q     <= selNext;
            sel_q     <= selNext;
            start_q   <= 1'b1;
            waitCnt_q <= '0;
            state_q   <= StWait;
          end
          StWait: begin
            if (sen_done_i)      state_q <= StCapture;
            else if (timeoutHit) state_q <= StNext;
            else                 waitCnt_q <= waitCnt_q + TimeoutW'(1);
          end
          StCapture: state_q <= StNext;
          StNext: begin
            if (moreLeft) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Status bits: a hardware set in the same cycle as a W1C clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      mask_q     <= '0;
      period_q   <= '0;
      timeout_q  <= '0;
      intrEn_q   <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      for (int n = 0; n < NumSensors; n++) data_q[n] <= '0;
    end else begin
      if (ctrlWe) begin
        enable_q   <= reg_wdata_i[0];
        periodic_q <= reg_wdata_i[1];
        mask_q     <= reg_wdata_i[7:4];
      end
      if (reg_we_i && (reg_addr_i == AddrPeriod))  period_q  <= reg_wdata_i;
      if (reg_we_i && (reg_addr_i == AddrTimeout)) timeout_q <= reg_wdata_i[TimeoutW-1:0];
      if (reg_we_i && (reg_addr_i == AddrIntrEn))  intrEn_q  <= reg_wdata_i[0];
      done_q <= (done_q & ~(statusWe & reg_wdata_i[StatusDoneBit])) | doneSet;
      terr_q <= (terr_q & ~(statusWe & reg_wdata_i[StatusTerrBit])) | terrSet;
      ovr_q  <= (ovr_q  & ~(statusWe & reg_wdata_i[StatusOvrBit]))  | ovrSet;
      for (int n = 0; n < NumSensors; n++) begin
        if (captureEn && (sel_q == 2'(n))) data_q[n] <= sen_data_i;
      end
    end
  end

`ifdef TSEN_CTRL_TIMESTAMP_EN
  logic [31:0] cycCnt_q, tstamp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycCnt_q <= '0;
      tstamp_q <= '0;
    end else begin
      cycCnt_q <= cycCnt_q + 32'd1;
      if (doneSet) tstamp_q <= cycCnt_q;
    end
  end
`endif

  // DATAn decode follows the case so DATA3 owns 0x1C when four sensors exist.
  always_comb begin
    reg_rdata_o = '0;
    unique case (reg_addr_i)
      AddrCtrl:    reg_rdata_o = {24'd0, mask_q, 2'b00, periodic_q, enable_q};
      AddrPeriod:  reg_rdata_o = period_q;
      AddrTimeout: reg_rdata_o = 32'(timeout_q);
      AddrStatus:  reg_rdata_o = {28'd0, ovr_q, terr_q, done_q, busy};
      AddrIntrEn:  reg_rdata_o = {31'd0, intrEn_q};
`ifdef TSEN_CTRL_TIMESTAMP_EN
      AddrTstamp:  reg_rdata_o = tstamp_q;
`endif
      default:     reg_rdata_o = '0;
    endcase
    for (int n = 0; n < NumSensors; n++) begin
      if (reg_addr_i == AddrData0 + 6'(4 * n)) reg_rdata_o = 32'(data_q[n]);
    end
  end

  assign sen_sel_o   = sel_q;
  assign sen_start_o = start_q;
  assign intr_o      = done_q & intrEn_q;

endmodule

// File: tb/tb_tsen_ctrl.sv
// Directed bench for tsen_ctrl: a start-pulse scoreboard plus register checks
// through sweeps, timeouts, periodic triggering, overrun, abort and reset.
module tb_tsen_ctrl;
  import tsen_ctrl_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             reg_we_i = 1'b0;
  logic             reg_re_i = 1'b0;
  logic [AddrW-1:0] reg_addr_i = '0;
  logic [31:0]      reg_wdata_i = '0;
  logic [31:0]      reg_rdata_o;
  logic [1:0]       sen_sel_o;
  logic             sen_start_o;
  logic             sen_done_i;
  logic [23:0]      sen_data_i;
  logic             intr_o;

  int         vectors = 0;
  int         miscompares = 0;
  int         tbCycle;
  int         lastDoneCycle = 0;
  bit         respOn = 1'b1;
  logic [1:0] expSel [$];
  int         startTimes [$];
  logic [23:0] respData [4];

  tsen_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .reg_we_i    (reg_we_i),
    .reg_re_i    (reg_re_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .sen_sel_o   (sen_sel_o),
    .sen_start_o (sen_start_o),
    .sen_done_i  (sen_done_i),
    .sen_data_i  (sen_data_i),
    .intr_o      (intr_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Reference cycle count, reset together with the DUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tbCycle <= 0;
    else         tbCycle <= tbCycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [AddrW-1:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    reg_we_i    = 1'b1;
    reg_addr_i  = addr;
    reg_wdata_i = data;
    @(negedge clk_i);
    reg_we_i    = 1'b0;
  endtask

  task automatic readReg(input logic [AddrW-1:0] addr, output logic [31:0] data);
    reg_addr_i = addr;
    reg_re_i   = 1'b1;
    #1;
    data       = reg_rdata_o;
    reg_re_i   = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    logic [31:0] s;
    int n = 0;
    readReg(AddrStatus, s);
    while (!s[StatusDoneBit] && n < budget) begin
      @(negedge clk_i);
      readReg(AddrStatus, s);
      n++;
    end
    checkOutput(tag, 32'(s[StatusDoneBit]), 32'd1);
  endtask

  task automatic checkReg(input string tag, input logic [AddrW-1:0] addr, input logic [31:0] expected);
    logic [31:0] r;
    readReg(addr, r);
    checkOutput(tag, r, expected);
  endtask

  // Sensor model: answers five cycles after a start pulse while enabled.
  initial begin
    sen_done_i = 1'b0;
    sen_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && respOn && sen_start_o) begin
        repeat (4) @(negedge clk_i);
        lastDoneCycle = tbCycle;
        sen_done_i    = 1'b1;
        sen_data_i    = respData[sen_sel_o];
        @(negedge clk_i);
        sen_done_i    = 1'b0;
        sen_data_i    = '0;
      end
    end
  end

  // Scoreboard: every start pulse must match the next expected sensor index.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && sen_start_o) begin
        startTimes.push_back(tbCycle);
        checkOutput("start_expected", 32'(expSel.size() != 0), 32'd1);
        if (expSel.size() != 0) begin
          e = expSel.pop_front();
          checkOutput("start_sel", 32'(sen_sel_o), 32'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    respData[0] = 24'h00ABCD;
    respData[1] = 24'h001234;
    respData[2] = 24'h000000;
    respData[3] = 24'h000000;

    // Reset state
    repeat (3) @(negedge clk_i);
    checkOutput("rst_start", 32'(sen_start_o), 32'd0);
    checkOutput("rst_sel", 32'(sen_sel_o), 32'd0);
    checkOutput("rst_intr", 32'(intr_o), 32'd0);
    checkReg("rst_status", AddrStatus, 32'h0);
    checkReg("rst_ctrl", AddrCtrl, 32'h0);
    rst_ni = 1'b1;

    // Two-sensor sweep with interrupt
    $display("[TB] sweep of two sensors");
    applyStimulus(AddrIntrEn, 32'h1);
    applyStimulus(AddrCtrl, 32'h31);
    expSel.push_back(2'd0);
    expSel.push_back(2'd1);
    applyStimulus(AddrCtrl, 32'h35);
    waitDone("sweep_done", 200);
    checkReg("sweep_data0", AddrData0, 32'h0000ABCD);
    checkReg("sweep_data1", AddrData0 + 6'h4, 32'h00001234);
    checkReg("sweep_status", AddrStatus, 32'h2);
    checkOutput("sweep_intr", 32'(intr_o), 32'd1);
    checkReg("ctrl_start_reads0", AddrCtrl, 32'h31);
    checkOutput("sweep_sb_empty", 32'(expSel.size()), 32'd0);
`ifdef TSEN_CTRL_TIMESTAMP_EN
    checkReg("tstamp", AddrTstamp, 32'(lastDoneCycle + 2));
`else
    checkReg("tstamp_absent", AddrTstamp, 32'h0);
`endif
    applyStimulus(AddrStatus, 32'h2);
    checkReg("done_w1c", AddrStatus, 32'h0);
    checkOutput("intr_cleared", 32'(intr_o), 32'd0);

    // Unmapped and absent-sensor addresses
    applyStimulus(6'h24, 32'hFFFFFFFF);
    checkReg("unmapped_read", 6'h24, 32'h0);
    checkReg("absent_data2", 6'h18, 32'h0);

    // Timeout on both sensors
    $display("[TB] timeout sweep");
    respOn = 1'b0;
    applyStimulus(AddrTimeout, 32'd8);
    startTimes.delete();
    expSel.push_back(2'd0);
    expSel.push_back(2'd1);
    applyStimulus(AddrCtrl, 32'h35);
    waitDone("timeout_done", 200);
    checkReg("timeout_status", AddrStatus, 32'h6);
    checkReg("timeout_data0_kept", AddrData0, 32'h0000ABCD);
    checkReg("timeout_data1_kept", AddrData0 + 6'h4, 32'h00001234);
    checkOutput("timeout_starts", 32'(startTimes.size()), 32'd2);
    if (startTimes.size() >= 2)
      checkOutput("timeout_spacing", 32'(startTimes[1] - startTimes[0]), 32'd10);
    applyStimulus(AddrStatus, 32'h6);
    applyStimulus(AddrTimeout, 32'd0);
    respOn = 1'b1;

    // Periodic triggering
    $display("[TB] periodic mode");
    applyStimulus(AddrPeriod, 32'd100);
    startTimes.delete();
    repeat (3) expSel.push_back(2'd0);
    applyStimulus(AddrCtrl, 32'h13);
    n = 0;
    while (startTimes.size() < 3 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("periodic_pulses", 32'(startTimes.size()), 32'd3);
    if (startTimes.size() >= 3) begin
      checkOutput("periodic_delta1", 32'(startTimes[1] - startTimes[0]), 32'd100);
      checkOutput("periodic_delta2", 32'(startTimes[2] - startTimes[1]), 32'd100);
    end
    applyStimulus(AddrPeriod, 32'd0);
    repeat (250) @(negedge clk_i);
    checkOutput("period0_no_pulses", 32'(startTimes.size()), 32'd3);
    checkOutput("periodic_sb_empty", 32'(expSel.size()), 32'd0);
    checkReg("periodic_status", AddrStatus, 32'h2);

    // Overrun, W1C priority and abort
    $display("[TB] overrun and abort");
    applyStimulus(AddrStatus, 32'hE);
    respOn = 1'b0;
    applyStimulus(AddrCtrl, 32'h11);
    expSel.push_back(2'd0);
    applyStimulus(AddrCtrl, 32'h15);
    applyStimulus(AddrCtrl, 32'h15);
    checkReg("overrun_set", AddrStatus, 32'h9);
    repeat (10) @(negedge clk_i);
    checkOutput("overrun_no_second", 32'(expSel.size()), 32'd0);
    applyStimulus(AddrStatus, 32'h8);
    checkReg("overrun_w1c", AddrStatus, 32'h1);
    applyStimulus(AddrPeriod, 32'd1);
    applyStimulus(AddrCtrl, 32'h13);
    applyStimulus(AddrStatus, 32'h8);
    checkReg("overrun_set_wins", AddrStatus, 32'h9);
    applyStimulus(AddrCtrl, 32'h00);
    checkReg("abort_status", AddrStatus, 32'h8);
    checkOutput("abort_no_start", 32'(sen_start_o), 32'd0);
    applyStimulus(AddrPeriod, 32'd0);
    applyStimulus(AddrCtrl, 32'h05);
    repeat (20) @(negedge clk_i);
    checkReg("mask0_idle", AddrStatus, 32'h8);
    applyStimulus(AddrStatus, 32'hE);
    checkReg("status_cleared", AddrStatus, 32'h0);

    // Reset in the middle of a sweep
    $display("[TB] reset mid-sweep");
    applyStimulus(AddrCtrl, 32'h21);
    expSel.push_back(2'd1);
    applyStimulus(AddrCtrl, 32'h25);
    repeat (3) @(negedge clk_i);
    checkOutput("pre_reset_sel", 32'(sen_sel_o), 32'd1);
    checkReg("pre_reset_busy", AddrStatus, 32'h1);
    rst_ni = 1'b0;
    #1;
    checkOutput("reset_sel", 32'(sen_sel_o), 32'd0);
    checkOutput("reset_start", 32'(sen_start_o), 32'd0);
    checkOutput("reset_intr", 32'(intr_o), 32'd0);
    checkReg("reset_status", AddrStatus, 32'h0);
    checkReg("reset_data0", AddrData0, 32'h0);
    checkReg("reset_intr_en", AddrIntrEn, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    respOn = 1'b1;
    repeat (5) @(negedge clk_i);
    checkOutput("final_sb_empty", 32'(expSel.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
